// File: rtl/vga_frame_buffer_if.sv
// Write-port bundle for vga_frame_buffer: valid/ready handshake carrying a
// store coordinate and a 12-bit colour.
interface vga_frame_buffer_if;
  logic        WR_VALID;
  logic        WR_READY;
  logic [7:0]  WR_X;
  logic [6:0]  WR_Y;
  logic [11:0] WR_RGB;

  modport master (output WR_VALID, WR_X, WR_Y, WR_RGB, input WR_READY);
  modport slave  (input WR_VALID, WR_X, WR_Y, WR_RGB, output WR_READY);
endinterface

// File: rtl/vga_frame_buffer.sv
// VGA pixel source: 160x120x12 frame store scaled 4x, 3-tick display pipeline,
// valid/ready write port and whole-store clear engine. Optional: FB_BORDER_EN.
module vga_frame_buffer #(
  parameter int unsigned FB_W     = 160,
  parameter int unsigned FB_H     = 120,
  parameter int unsigned SCALE_SH = 2
`ifdef FB_BORDER_EN
  ,
  parameter logic [11:0] BORDER_RGB = 12'hF00
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PIX_CE,
  input  logic                     IN_HS,
  input  logic                     IN_VS,
  input  logic                     IN_DE,
  input  logic [9:0]               IN_X,
  input  logic [9:0]               IN_Y,
  vga_frame_buffer_if.slave        wr,
  input  logic                     CLR_REQ,
  input  logic [11:0]              CLR_RGB,
  output logic                     BUSY,
  output logic [3:0]               VGA_R,
  output logic [3:0]               VGA_G,
  output logic [3:0]               VGA_B,
  output logic                     VGA_HS,
  output logic                     VGA_VS
);
  localparam int unsigned   DEPTH = FB_W * FB_H;
  localparam int unsigned   AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [9:0]    FB_W10 = 10'(FB_W);
  localparam logic [9:0]    FB_H10 = 10'(FB_H);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  logic [11:0]   mem [0:DEPTH-1];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [11:0]   clr_rgb_q, clr_rgb_d;

  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [11:0]   wdata_s;
  logic          wr_in_range_s;
  logic [AW-1:0] wr_addr_s;

  logic [9:0]    xs_s, ys_s;
  logic          ok_s;
  logic [AW-1:0] addr_calc_s;

  logic [AW-1:0] addr1_q, addr1_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, ok1_q, ok1_d;
  logic          hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d, ok2_q, ok2_d;
  logic [11:0]   rd_q;
  logic [11:0]   rgb3_q, rgb3_d;
  logic          hs3_q, hs3_d, vs3_q, vs3_d;
`ifdef FB_BORDER_EN
  logic          edge_s;
  logic          edge1_q, edge1_d, edge2_q, edge2_d;
`endif

  // Display coordinate to store address; out-of-store coordinates park on word 0.
  always_comb begin
    xs_s = IN_X >> SCALE_SH;
    ys_s = IN_Y >> SCALE_SH;
    ok_s = (xs_s < FB_W10) && (ys_s < FB_H10);
    if (FB_W == 160) begin
      addr_calc_s = AW'({ys_s, 7'd0}) + AW'({ys_s, 5'd0}) + AW'(xs_s);
    end else begin
      addr_calc_s = AW'(ys_s) * AW'(FB_W) + AW'(xs_s);
    end
`ifdef FB_BORDER_EN
    edge_s = IN_DE && ((IN_X == 10'd0) || (IN_X == 10'd639) ||
                       (IN_Y == 10'd0) || (IN_Y == 10'd479));
`endif
  end

  // Write-port address decode and range check.
  always_comb begin
    wr_in_range_s = ({2'b00, wr.WR_X} < FB_W10) && ({3'b000, wr.WR_Y} < FB_H10);
    wr_addr_s     = AW'(wr.WR_Y) * AW'(FB_W) + AW'(wr.WR_X);
  end

  // Clear FSM next state and the single store write port it arbitrates.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_rgb_d = clr_rgb_q;
    we_s      = 1'b0;
    waddr_s   = {AW{1'b0}};
    wdata_s   = 12'h000;
    case (state_q)
      ST_IDLE: begin
        if (wr.WR_VALID && wr_in_range_s) begin
          we_s    = 1'b1;
          waddr_s = wr_addr_s;
          wdata_s = wr.WR_RGB;
        end else begin
          we_s = 1'b0;
        end
        if (CLR_REQ) begin
          state_d   = ST_CLEAR;
          ptr_d     = {AW{1'b0}};
          clr_rgb_d = CLR_RGB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = ptr_q;
        wdata_s = clr_rgb_q;
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = {AW{1'b0}};
        end else begin
          ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear FSM state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= {AW{1'b0}};
      clr_rgb_q <= 12'h000;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_rgb_q <= clr_rgb_d;
    end
  end

  // Frame store; the read sees pre-write data on a same-address collision.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
    if (PIX_CE) begin
      rd_q <= mem[addr1_q];
    end
  end

  // Display pipeline next state; everything holds while PIX_CE is low.
  always_comb begin
    addr1_d = addr1_q; hs1_d = hs1_q; vs1_d = vs1_q; de1_d = de1_q; ok1_d = ok1_q;
    hs2_d   = hs2_q;   vs2_d = vs2_q; de2_d = de2_q; ok2_d = ok2_q;
    rgb3_d  = rgb3_q;  hs3_d = hs3_q; vs3_d = vs3_q;
`ifdef FB_BORDER_EN
    edge1_d = edge1_q; edge2_d = edge2_q;
`endif
    if (PIX_CE) begin
      addr1_d = ok_s ? addr_calc_s : {AW{1'b0}};
      hs1_d = IN_HS; vs1_d = IN_VS; de1_d = IN_DE; ok1_d = ok_s;
      hs2_d = hs1_q; vs2_d = vs1_q; de2_d = de1_q; ok2_d = ok1_q;
      hs3_d = hs2_q; vs3_d = vs2_q;
`ifdef FB_BORDER_EN
      edge1_d = edge_s;
      edge2_d = edge1_q;
      if (edge2_q) begin
        rgb3_d = BORDER_RGB;
      end else if (de2_q && ok2_q) begin
        rgb3_d = rd_q;
      end else begin
        rgb3_d = 12'h000;
      end
`else
      if (de2_q && ok2_q) begin
        rgb3_d = rd_q;
      end else begin
        rgb3_d = 12'h000;
      end
`endif
    end else begin
      addr1_d = addr1_q;
    end
  end

  // Display pipeline registers; sync stages reset high, enables low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr1_q <= {AW{1'b0}};
      hs1_q <= 1'b1; vs1_q <= 1'b1; de1_q <= 1'b0; ok1_q <= 1'b0;
      hs2_q <= 1'b1; vs2_q <= 1'b1; de2_q <= 1'b0; ok2_q <= 1'b0;
      rgb3_q <= 12'h000; hs3_q <= 1'b1; vs3_q <= 1'b1;
`ifdef FB_BORDER_EN
      edge1_q <= 1'b0; edge2_q <= 1'b0;
`endif
    end else begin
      addr1_q <= addr1_d;
      hs1_q <= hs1_d; vs1_q <= vs1_d; de1_q <= de1_d; ok1_q <= ok1_d;
      hs2_q <= hs2_d; vs2_q <= vs2_d; de2_q <= de2_d; ok2_q <= ok2_d;
      rgb3_q <= rgb3_d; hs3_q <= hs3_d; vs3_q <= vs3_d;
`ifdef FB_BORDER_EN
      edge1_q <= edge1_d; edge2_q <= edge2_d;
`endif
    end
  end

  assign wr.WR_READY = (state_q == ST_IDLE);
  assign BUSY        = (state_q == ST_CLEAR);
  assign VGA_R       = rgb3_q[11:8];
  assign VGA_G       = rgb3_q[7:4];
  assign VGA_B       = rgb3_q[3:0];
  assign VGA_HS      = hs3_q;
  assign VGA_VS      = vs3_q;
endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
- Pixel-source stage that sits directly upstream of the VGA output pins. It consumes the scan timing produced by the VGA timing/sync stage: sync levels, display-enable and the display-relative pixel coordinate.
- It returns registered RGB plus sync, delayed by a fixed latency so colour and sync stay aligned.
- Pixel data comes from an on-chip 160x120x12-bit frame store, scaled 4x to 640x480.
- Drawing logic fills the store through a valid/ready write port. A clear engine fills the whole store with one colour.

Parameters:
- FB_W, 160, frame store width in stored pixels.
- FB_H, 120, frame store height in stored pixels.
- SCALE_SH, 2, log2 of the scale factor; a display coordinate maps to a store coordinate by shifting right SCALE_SH bits.
- BORDER_RGB, 12'hF00, border colour used only under FB_BORDER_EN.

Ports:
- CLK  in  1  system clock (50 MHz); the only clock.
- RST  in  1  asynchronous, active-high reset.
- PIX_CE  in  1  pixel clock enable, one CLK in two; the display pipeline advances only when this is 1.
- IN_HS  in  1  horizontal sync level from the timing stage.
- IN_VS  in  1  vertical sync level from the timing stage.
- IN_DE  in  1  1 inside the 640x480 visible area.
- IN_X  in  10  display column 0..639, valid when IN_DE=1.
- IN_Y  in  10  display row 0..479, valid when IN_DE=1.
- WR_VALID  in  1  write request.
- WR_READY  out  1  write accepted when WR_VALID and WR_READY are both 1 on a CLK edge.
- WR_X  in  8  store column.
- WR_Y  in  7  store row.
- WR_RGB  in  12  {R[3:0],G[3:0],B[3:0]}.
- CLR_REQ  in  1  one-cycle pulse; starts a whole-store clear.
- CLR_RGB  in  12  clear colour, sampled when CLR_REQ is accepted.
- BUSY  out  1  1 while a clear is running.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.
- VGA_HS  out  1  sync level, delayed to match RGB.
- VGA_VS  out  1  sync level, delayed to match RGB.

Behaviour:
- Reset (async, immediate):
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1.
  - BUSY=0, WR_READY=1, FSM=IDLE, all pipeline registers cleared (DE stages=0, sync stages=1).
  - Frame store contents are not reset.
- Display pipeline: 3 stages, each advancing only on CLK edges with PIX_CE=1.
  - S1 registers addr = (IN_Y>>SCALE_SH)*FB_W + (IN_X>>SCALE_SH), 15 bits, computed as (y<<7)+(y<<5)+x for the defaults. It also registers HS/VS/DE and, under FB_BORDER_EN, the edge flag.
  - S2 performs a synchronous RAM read, q <= mem[addr], and delays the controls.
  - S3 sets output RGB = DE ? q : 0 and outputs the delayed HS/VS.
  - Latency: outputs reflect inputs sampled exactly 3 PIX_CE ticks earlier. With PIX_CE=0 all pipeline and output registers hold.
- Address clamp: if IN_DE=1 but the scaled coordinate is >= FB_W or FB_H (only possible with a non-default config), S3 outputs 0.
- Write port (every CLK, independent of PIX_CE):
  - On an accepted write with WR_X<FB_W and WR_Y<FB_H, mem[WR_Y*FB_W+WR_X] <= WR_RGB.
  - An out-of-range write is accepted (handshake completes) and dropped.
  - WR_READY = (state==IDLE).
- Read/write collision on the same address and edge: the read returns the old data (read-before-write).
- FSM:
  - IDLE: CLR_REQ=1 latches CLR_RGB, sets ptr=0, moves to CLEAR, and sets BUSY=1 on the next edge.
  - If CLR_REQ and a write handshake occur in the same IDLE cycle, the write completes first and the clear starts on the same edge.
  - CLEAR: each CLK writes mem[ptr]=clr colour and increments ptr.
  - When ptr==FB_W*FB_H-1 the FSM writes that word, returns to IDLE and clears BUSY on that edge. A clear therefore takes exactly 19200 CLK cycles.
  - CLR_REQ during CLEAR is ignored; the clear is not restarted.
  - WR_VALID during CLEAR is stalled, because WR_READY=0.
- The display keeps reading during a clear, so a partially cleared frame is visible; no tearing protection.
- Reset during CLEAR aborts it: FSM=IDLE, BUSY=0, memory left partially cleared.

Optional Feature:
- Macro: FB_BORDER_EN.
- Defined: when IN_DE=1 and (IN_X==0 or IN_X==639 or IN_Y==0 or IN_Y==479), the output pixel is BORDER_RGB instead of store data. The flag is pipelined with the same 3-tick latency.
- Undefined: no edge comparators exist; all visible pixels come from the store.

Test Plan:
1. Write (5,7)=12'h0A5, then drive IN_DE=1, X=20..23, Y=28..31 -> VGA_RGB={0,A,5} on exactly those 16 display pixels, 3 PIX_CE ticks after each input pixel.
2. Toggle IN_HS/IN_VS with PIX_CE alternating -> VGA_HS/VS equal the inputs delayed 3 PIX_CE ticks. Hold PIX_CE=0 for 10 CLK -> all outputs frozen.
3. Pulse CLR_REQ with CLR_RGB=12'h00F -> BUSY high for 19200 CLK and WR_READY=0 throughout. Afterwards every pixel reads 12'h00F; a second CLR_REQ mid-clear does not extend BUSY.
4. Write WR_X=160 (out of range) -> handshake completes in 1 CLK and no store word changes. IN_DE=0 anywhere -> RGB=0.
5. Assert RST at clear word 1000 -> BUSY=0, WR_READY=1 and VGA_HS=VGA_VS=1 immediately (async). Words 0..999 hold the clear colour and word 1000 onward is unchanged.
6. With FB_BORDER_EN defined: X=0/639 or Y=0/479 output 12'hF00; X=1,Y=1 outputs store data.
